chip_scan_sequencer: RTL
========================

# chip_scan_sequencer

Frame-scan sequencer for the speckle sensor chip. It walks a single-'1' token through the chip's row and column shift registers, triggers one ADC conversion per pixel, and emits a raster-ordered pixel stream tagged with row and column. It sits between the sensor controller's register block and the chip and ADC pins, and replaces ad-hoc software bit-banging of the shift-register signals.

## Interface
- COLS, 24: columns per frame.
- ROWS, 24: rows per frame.
- NB_DATA, 12: ADC sample width.
- NB_DIV, 16: width of the shift-clock divider.
- ADC_TIMEOUT, 1023: cycles to wait for i_adc_done; used only with SCAN_ADC_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse that starts one frame; ignored while busy.
- i_abort  in  1  one-cycle pulse that aborts the frame in progress.
- i_clk_div_sr  in  NB_DIV  tick period T in cycles; 0 is treated as 1; latched on start.
- i_adc_val  in  NB_DATA  conversion result, valid when i_adc_done is high.
- i_adc_done  in  1  one-cycle conversion-complete pulse.
- o_adc_trigger  out  1  one-cycle conversion request.
- o_chip_row_clk, o_chip_row_rst, o_chip_row_ena, o_chip_row_data  out  1 each  row shift-register pins.
- o_chip_col_clk, o_chip_col_rst, o_chip_col_data  out  1 each  column shift-register pins.
- o_pix_valid  out  1  one-cycle pixel strobe.
- o_pix_data  out  NB_DATA  pixel sample.
- o_pix_row  out  $clog2(ROWS)  pixel row index.
- o_pix_col  out  $clog2(COLS)  pixel column index.
- o_busy  out  1  high in every state except IDLE.
- o_frame_done  out  1  one-cycle end-of-frame pulse.
- o_timeout  out  1  sticky ADC-timeout flag.

## Operation
- **Ticks:** a tick counter restarts on every state entry. A tick elapses every T cycles.
- **IDLE:** all outputs are 0. i_start latches T, sets r=0 and c=0, and moves to RST.
- **RST:** drives row_rst and col_rst high for 2 ticks, then moves to ROW_SH.
- **ROW_SH:** drives row_data = (r==0) for the whole state. Tick 1 holds row_clk low; tick 2 drives row_clk high. On exit, row_clk returns to 0 and the state moves to COL_SH.
- **COL_SH:** same as ROW_SH on the column pins, with col_data = (c==0). Moves to SETTLE.
- **SETTLE:** drives row_ena high for 1 tick, then moves to CONV.
- **CONV:**
  - row_ena stays high.
  - o_adc_trigger is high on the first CONV cycle only.
  - An i_adc_done coincident with the trigger cycle is ignored.
  - On the first i_adc_done after the trigger cycle, the block registers i_adc_val, r and c. o_pix_valid is driven the next cycle.
- **Next pixel after CONV:**
  - If c<COLS-1: c++ and go to COL_SH.
  - Else if r<ROWS-1: c=0, r++ and go to COLRST.
  - Else go to DONE.
- **COLRST:** drives col_rst high for 1 tick, then moves to ROW_SH.
- **DONE:** pulses o_frame_done for 1 cycle, then moves to IDLE.
- **Abort:** i_abort in any non-IDLE state moves to IDLE on the next cycle. All chip pins are driven to 0, no pixel or frame_done is emitted, and any pending pixel is discarded.
- **Reset mid-frame:** identical to abort. o_timeout also clears.
- **Simultaneous events:**
  - i_start and i_abort in the same IDLE cycle: abort wins and the block stays in IDLE.
  - i_adc_done outside CONV is ignored.
- **Frame content:** exactly ROWS*COLS pixels in raster order, row-major with column fastest.

## Timing
- Reset value of every output is 0.
- With i_start accepted at cycle 0:
  - RST is entered at cycle 1.
  - The first o_adc_trigger is at cycle 1+7T.
- The pixel strobe is 1 cycle after the accepted i_adc_done.
- The next state is entered in the same cycle as o_pix_valid.
- Pixel period within a row is 3T+L+1, where L is the trigger-to-done latency.
- Row change adds 3T.
- o_frame_done is asserted 1 cycle after the last o_pix_valid. o_busy falls in the same cycle.

## Configuration
- **SCAN_ADC_TIMEOUT_EN defined:**
  - A counter runs during CONV.
  - If no i_adc_done arrives within ADC_TIMEOUT cycles after the trigger, the block emits the pixel with o_pix_data all ones and sets o_timeout.
  - o_timeout is cleared by i_start or i_rst.
  - The scan then continues normally.
- **SCAN_ADC_TIMEOUT_EN undefined:** CONV waits indefinitely and o_timeout is tied to 0.

## Test plan
- **Full frame, ROWS=COLS=4, T=1, ADC returns done 3 cycles after trigger:**
  - 16 pixels in raster order with correct row/col tags and data.
  - First trigger at cycle 8.
  - Intra-row pixel period 7 cycles.
  - o_frame_done once.
- **T=3:** row/col clk high-phase is 3 cycles. RST is held 6 cycles. First trigger at cycle 22.
- **T=0:** behaviour identical to T=1.
- **Abort during the CONV of pixel (1,2):**
  - Pins go to 0 and the block is IDLE the next cycle.
  - No further pix_valid and no frame_done.
  - A new i_start rescans from (0,0).
- **Mid-frame disturbances:**
  - i_start while busy is ignored.
  - i_adc_done on the trigger cycle is ignored; the later done is accepted.
  - Synchronous i_rst mid-frame returns all outputs to 0.
- **With SCAN_ADC_TIMEOUT_EN, ADC_TIMEOUT=20, ADC never responds:**
  - Each pixel is emitted 20 cycles after its trigger as 0xFFF.
  - o_timeout is set; the frame completes.
  - Without the macro, the bench checks that the block stalls in CONV.

Source files
------------

// File: rtl/chip_scan_sequencer.sv
// chip_scan_sequencer: walks a single-'1' token through the sensor's row and
// column shift registers, requests one ADC conversion per pixel and emits a
// raster-ordered pixel stream tagged with row/column.
// Optional feature macro: SCAN_ADC_TIMEOUT_EN (ADC watchdog, sticky o_timeout).
module chip_scan_sequencer #(
   parameter int COLS        = 24,
   parameter int ROWS        = 24,
   parameter int NB_DATA     = 12,
   parameter int NB_DIV      = 16,
   parameter int ADC_TIMEOUT = 1023
) (
   input  logic                     clk,
   input  logic                     i_rst,
   input  logic                     i_start,
   input  logic                     i_abort,
   input  logic [NB_DIV-1:0]        i_clk_div_sr,
   input  logic [NB_DATA-1:0]       i_adc_val,
   input  logic                     i_adc_done,
   output logic                     o_adc_trigger,
   output logic                     o_chip_row_clk,
   output logic                     o_chip_row_rst,
   output logic                     o_chip_row_ena,
   output logic                     o_chip_row_data,
   output logic                     o_chip_col_clk,
   output logic                     o_chip_col_rst,
   output logic                     o_chip_col_data,
   output logic                     o_pix_valid,
   output logic [NB_DATA-1:0]       o_pix_data,
   output logic [$clog2(ROWS)-1:0]  o_pix_row,
   output logic [$clog2(COLS)-1:0]  o_pix_col,
   output logic                     o_busy,
   output logic                     o_frame_done,
   output logic                     o_timeout
);
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);

   typedef enum logic [2:0] {IDLE, RST, ROW_SH, COL_SH, SETTLE, CONV, COLRST, DONE} state_t;
   state_t state, state_nx;

   logic [NB_DIV-1:0] period, div_cnt;
   logic              tick_num;   // 0 during the first tick of a state, 1 afterwards
   logic              first;      // first cycle after a state entry
   logic [RW-1:0]     r;
   logic [CW-1:0]     c;
   logic              tick_end, start_ok, adc_ok, timed_out, pix_done, pix_take;
   logic              last_col, last_row;

   assign tick_end = (div_cnt == period - 1'b1);
   assign start_ok = (state == IDLE) && i_start && !i_abort;
   // a done landing on the trigger cycle belongs to an earlier request
   assign adc_ok   = (state == CONV) && !first && i_adc_done;
   assign pix_done = adc_ok | timed_out;
   assign pix_take = pix_done && !i_abort;
   assign last_col = (c == CW'(COLS - 1));
   assign last_row = (r == RW'(ROWS - 1));

`ifdef SCAN_ADC_TIMEOUT_EN
   localparam int WD_W = $clog2(ADC_TIMEOUT + 1);
   logic [WD_W-1:0] wd_cnt;
   logic            timeout_q;

   // the trigger cycle counts as 0, so the pixel appears ADC_TIMEOUT cycles after it
   assign timed_out = (state == CONV) && !adc_ok && (wd_cnt == WD_W'(ADC_TIMEOUT - 1));
   assign o_timeout = timeout_q;

   // watchdog cycle count inside CONV
   always_ff @(posedge clk) begin
      if (i_rst || state != CONV) wd_cnt <= '0;
      else                        wd_cnt <= wd_cnt + 1'b1;
   end

   // sticky timeout flag, cleared when a new frame starts
   always_ff @(posedge clk) begin
      if (i_rst || start_ok)          timeout_q <= 1'b0;
      else if (timed_out && !i_abort) timeout_q <= 1'b1;
   end
`else
   assign timed_out = 1'b0;
   // constant-false: no watchdog in this build
   assign o_timeout = (ADC_TIMEOUT < 0);
`endif

   // state register
   always_ff @(posedge clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nx;
   end

   // next-state logic; abort overrides everything
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start_ok) state_nx = RST;
         RST:     if (tick_end && tick_num) state_nx = ROW_SH;
         ROW_SH:  if (tick_end && tick_num) state_nx = COL_SH;
         COL_SH:  if (tick_end && tick_num) state_nx = SETTLE;
         SETTLE:  if (tick_end) state_nx = CONV;
         CONV:    if (pix_done) begin
                     if (!last_col)      state_nx = COL_SH;
                     else if (!last_row) state_nx = COLRST;
                     else                state_nx = DONE;
                  end
         COLRST:  if (tick_end) state_nx = ROW_SH;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (i_abort) state_nx = IDLE;
   end

   // output decode from state and tick phase
   always_comb begin
      o_adc_trigger   = 1'b0;
      o_chip_row_clk  = 1'b0;
      o_chip_row_rst  = 1'b0;
      o_chip_row_ena  = 1'b0;
      o_chip_row_data = 1'b0;
      o_chip_col_clk  = 1'b0;
      o_chip_col_rst  = 1'b0;
      o_chip_col_data = 1'b0;
      case (state)
         RST:    begin o_chip_row_rst = 1'b1; o_chip_col_rst = 1'b1; end
         ROW_SH: begin o_chip_row_data = (r == '0); o_chip_row_clk = tick_num; end
         COL_SH: begin o_chip_col_data = (c == '0); o_chip_col_clk = tick_num; end
         SETTLE: o_chip_row_ena = 1'b1;
         CONV:   begin o_chip_row_ena = 1'b1; o_adc_trigger = first; end
         COLRST: o_chip_col_rst = 1'b1;
         default: ;
      endcase
   end

   assign o_busy = (state != IDLE);

   // tick divider and tick index, restarted on every state entry
   always_ff @(posedge clk) begin
      if (i_rst) begin
         div_cnt <= '0; tick_num <= 1'b0; first <= 1'b0;
      end else if (state_nx != state) begin
         div_cnt <= '0; tick_num <= 1'b0; first <= 1'b1;
      end else begin
         first <= 1'b0;
         if (tick_end) begin
            div_cnt  <= '0;
            tick_num <= 1'b1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   // frame bookkeeping: tick period and raster position
   always_ff @(posedge clk) begin
      if (i_rst) begin
         period <= '0; r <= '0; c <= '0;
      end else if (start_ok) begin
         period <= (i_clk_div_sr == '0) ? NB_DIV'(1) : i_clk_div_sr;
         r <= '0; c <= '0;
      end else if (pix_take) begin
         if (!last_col) c <= c + 1'b1;
         else begin
            c <= '0;
            if (!last_row) r <= r + 1'b1;
         end
      end
   end

   // pixel and end-of-frame strobes; fields are zero outside the strobe
   always_ff @(posedge clk) begin
      if (i_rst) begin
         o_pix_valid <= 1'b0; o_pix_data <= '0; o_pix_row <= '0; o_pix_col <= '0;
         o_frame_done <= 1'b0;
      end else begin
         o_pix_valid  <= pix_take;
         o_pix_data   <= pix_take ? (adc_ok ? i_adc_val : '1) : '0;
         o_pix_row    <= pix_take ? r : '0;
         o_pix_col    <= pix_take ? c : '0;
         o_frame_done <= (state == DONE) && !i_abort;
      end
   end
endmodule
